vend_controller: RTL and testbench

Transaction sequencer for the vending machine purchase datapath. It accepts a product selection, presents the selected product and quantity to the pricing datapath, and latches the returned discounted price as the amount due. It then accumulates coin credit and, once credit covers the amount due, dispenses from internal per-product stock counters and returns change through a handshake. It sits between the user-facing inputs (keypad, coin acceptor, change hopper) and the combinational price/discount/remaining datapath.

---
 rtl/vend_controller.sv | 182 ++++++++++++++++++
 tb/tb_vend_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending purchase sequencer: select, price, collect coins, dispense, change.
// Optional PAY inactivity refund is enabled with `define VEND_TIMEOUT_EN.
module vend_controller #(
  parameter int NUM_PRODUCTS   = 8,
  parameter int STOCK_W        = 4,
  parameter int INIT_STOCK     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_valid,
  input  logic [2:0]  product_id,
  input  logic [3:0]  quantity,
  input  logic        coin_valid,
  input  logic [7:0]  coin_value,
  input  logic        cancel,
  input  logic [15:0] discounted_price,
  input  logic        change_ack,
  input  logic        restock_valid,
  input  logic [2:0]  restock_id,
  input  logic [3:0]  restock_qty,
  output logic [2:0]  sel_id,
  output logic [3:0]  sel_qty,
  output logic [15:0] due_amount,
  output logic [15:0] credit,
  output logic        coin_ready,
  output logic        vend_valid,
  output logic [2:0]  vend_id,
  output logic [3:0]  vend_qty,
  output logic        change_valid,
  output logic [15:0] change_amount,
  output logic        error_valid,
  output logic [1:0]  error_code,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, PRICE, PAY, DISPENSE, CHANGE
  } state_t;

  localparam logic [16:0] STOCK_MAX =
    17'((1 << STOCK_W) - 1);

  state_t state;
  logic [STOCK_W-1:0] stock [NUM_PRODUCTS];

  logic [16:0] coin_sum;
  logic [15:0] credit_nxt;
  logic        pay_done;
  logic [16:0] rs_sum;
  logic [STOCK_W-1:0] rs_val;
  logic        short_stock;
  logic [15:0] refund;

  assign coin_sum = {1'b0, credit}
    + (coin_valid ? {9'd0, coin_value} : 17'd0);
  assign credit_nxt = coin_sum[16] ? 16'hFFFF
                                   : coin_sum[15:0];
  assign pay_done = credit_nxt >= due_amount;

  // restock saturates at the counter ceiling
  assign rs_sum = 17'(stock[restock_id])
                + 17'(restock_qty);
  assign rs_val = (rs_sum > STOCK_MAX)
                ? STOCK_W'(STOCK_MAX)
                : STOCK_W'(rs_sum);

  assign short_stock =
    16'(stock[product_id]) < 16'(quantity);
  assign refund = credit - due_amount;

  assign coin_ready = (state == PAY);
  assign busy       = (state != IDLE);

`ifdef VEND_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD =
    TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] tmr;
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sel_id        <= '0;
      sel_qty       <= '0;
      due_amount    <= '0;
      credit        <= '0;
      change_amount <= '0;
      change_valid  <= 1'b0;
      vend_valid    <= 1'b0;
      vend_id       <= '0;
      vend_qty      <= '0;
      error_valid   <= 1'b0;
      error_code    <= '0;
      for (int i = 0; i < NUM_PRODUCTS; i++)
        stock[i] <= STOCK_W'(INIT_STOCK);
`ifdef VEND_TIMEOUT_EN
      tmr <= '0;
`endif
    end else begin
      vend_valid  <= 1'b0;
      error_valid <= 1'b0;
      error_code  <= '0;
      unique case (state)
        IDLE: begin
          if (restock_valid)
            stock[restock_id] <= rs_val;
          if (sel_valid) begin
            sel_id  <= product_id;
            sel_qty <= quantity;
            unique case (1'b1)
              (quantity == '0): begin
                error_valid <= 1'b1;
                error_code  <= 2'd1;
              end
              short_stock: begin
                error_valid <= 1'b1;
                error_code  <= 2'd2;
              end
              default: state <= PRICE;
            endcase
          end
        end
        PRICE: begin
          due_amount <= discounted_price;
          state      <= PAY;
`ifdef VEND_TIMEOUT_EN
          tmr <= TMR_LOAD;
`endif
        end
        PAY: begin
          credit <= credit_nxt;
          if (cancel) begin
            change_amount <= credit_nxt;
            change_valid  <= (credit_nxt != '0);
            state         <= CHANGE;
          end else if (pay_done) begin
            vend_valid <= 1'b1;
            vend_id    <= sel_id;
            vend_qty   <= sel_qty;
            state      <= DISPENSE;
          end
`ifdef VEND_TIMEOUT_EN
          else if (coin_valid) begin
            tmr <= TMR_LOAD;
          end else if (tmr == '0) begin
            error_valid   <= 1'b1;
            error_code    <= 2'd3;
            change_amount <= credit;
            change_valid  <= (credit != '0);
            state         <= CHANGE;
          end else begin
            tmr <= tmr - 1'b1;
          end
`endif
        end
        DISPENSE: begin
          stock[sel_id] <= stock[sel_id]
                         - STOCK_W'(sel_qty);
          change_amount <= refund;
          change_valid  <= (refund != '0);
          state         <= CHANGE;
        end
        CHANGE: begin
          if (!change_valid || change_ack) begin
            credit        <= '0;
            due_amount    <= '0;
            change_amount <= '0;
            change_valid  <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Randomized bench for vend_controller against a transaction-level model.
// Default build only: the timeout refund is not exercised here.
module tb_vend_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel_valid;
  logic [2:0]  product_id;
  logic [3:0]  quantity;
  logic        coin_valid;
  logic [7:0]  coin_value;
  logic        cancel;
  logic [15:0] discounted_price;
  logic        change_ack;
  logic        restock_valid;
  logic [2:0]  restock_id;
  logic [3:0]  restock_qty;
  logic [2:0]  sel_id;
  logic [3:0]  sel_qty;
  logic [15:0] due_amount;
  logic [15:0] credit;
  logic        coin_ready;
  logic        vend_valid;
  logic [2:0]  vend_id;
  logic [3:0]  vend_qty;
  logic        change_valid;
  logic [15:0] change_amount;
  logic        error_valid;
  logic [1:0]  error_code;
  logic        busy;

  vend_controller dut (
    .clk(clk), .reset(reset),
    .sel_valid(sel_valid), .product_id(product_id),
    .quantity(quantity), .coin_valid(coin_valid),
    .coin_value(coin_value), .cancel(cancel),
    .discounted_price(discounted_price),
    .change_ack(change_ack),
    .restock_valid(restock_valid),
    .restock_id(restock_id),
    .restock_qty(restock_qty),
    .sel_id(sel_id), .sel_qty(sel_qty),
    .due_amount(due_amount), .credit(credit),
    .coin_ready(coin_ready), .vend_valid(vend_valid),
    .vend_id(vend_id), .vend_qty(vend_qty),
    .change_valid(change_valid),
    .change_amount(change_amount),
    .error_valid(error_valid),
    .error_code(error_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int stock_m [8];
  int credit_m;
  int steps [$];

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    sel_valid     = 1'b0;
    coin_valid    = 1'b0;
    cancel        = 1'b0;
    change_ack    = 1'b0;
    restock_valid = 1'b0;
  endtask

  function automatic int sat_stock(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic do_restock(int id, int qty);
    restock_valid = 1'b1;
    restock_id    = 3'(id);
    restock_qty   = 4'(qty);
    tick();
    restock_valid = 1'b0;
    stock_m[id] = sat_stock(stock_m[id] + qty);
    check("restock_busy", busy, 0);
  endtask

  task automatic select(input int id, qty, price,
                        input bit rs,
                        input int rid, rqty,
                        output bit ok);
    int e;
    sel_valid        = 1'b1;
    product_id       = 3'(id);
    quantity         = 4'(qty);
    discounted_price = 16'(price);
    restock_valid    = rs;
    restock_id       = 3'(rid);
    restock_qty      = 4'(rqty);
    tick();
    sel_valid     = 1'b0;
    restock_valid = 1'b0;
    e = (qty == 0) ? 1 : (stock_m[id] < qty) ? 2 : 0;
    if (rs)
      stock_m[rid] = sat_stock(stock_m[rid] + rqty);
    ok = (e == 0);
    check("sel_id", sel_id, id);
    check("sel_qty", sel_qty, qty);
    check("err_valid", error_valid, e != 0);
    check("err_code", error_code, e);
    check("sel_busy", busy, ok);
    if (ok) begin
      check("price_coin_ready", coin_ready, 0);
      tick();
      check("due", due_amount, price);
      check("pay_coin_ready", coin_ready, 1);
    end else begin
      tick();
      check("err_pulse", error_valid, 0);
      check("err_clr", error_code, 0);
      check("err_busy", busy, 0);
    end
  endtask

  // steps: bit9 cancel, bit8 coin_valid, [7:0] coin value
  task automatic pay(input int id, qty, price,
                     input int extra);
    int i, s, res, chg;
    i = 0;
    res = 0;
    credit_m = 0;
    while (res == 0) begin
      s = (i < steps.size()) ? steps[i] : 'h200;
      coin_valid    = s[8];
      coin_value    = s[7:0];
      cancel        = s[9];
      restock_valid = 1'($urandom_range(0, 1));
      restock_id    = 3'($urandom);
      restock_qty   = 4'($urandom);
      sel_valid     = 1'($urandom_range(0, 1));
      product_id    = 3'($urandom);
      quantity      = 4'($urandom);
      tick();
      clear_in();
      if (s[8]) begin
        credit_m = credit_m + s[7:0];
        if (credit_m > 65535) credit_m = 65535;
      end
      if (s[9]) res = 2;
      else if (credit_m >= price) res = 1;
      if (res == 0) begin
        check("pay_credit", credit, credit_m);
        check("pay_ready", coin_ready, 1);
        check("pay_no_vend", vend_valid, 0);
      end
      i++;
    end
    if (res == 1) begin
      check("vend_valid", vend_valid, 1);
      check("vend_id", vend_id, id);
      check("vend_qty", vend_qty, qty);
      check("disp_ready", coin_ready, 0);
      stock_m[id] = stock_m[id] - qty;
      chg = credit_m - price;
      coin_valid = 1'b1;
      coin_value = 8'(extra);
      tick();
      coin_valid = 1'b0;
      check("vend_pulse", vend_valid, 0);
    end else begin
      chg = credit_m;
      check("cancel_no_vend", vend_valid, 0);
    end
    check("chg_credit", credit, credit_m);
    check("chg_valid", change_valid, chg != 0);
    check("chg_amount", change_amount, chg);
    if (chg != 0) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("chg_hold_v", change_valid, 1);
        check("chg_hold_a", change_amount, chg);
      end
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
    end else begin
      change_ack = 1'($urandom_range(0, 1));
      tick();
      change_ack = 1'b0;
    end
    check("end_busy", busy, 0);
    check("end_credit", credit, 0);
    check("end_due", due_amount, 0);
    check("end_chg_v", change_valid, 0);
    check("end_chg_a", change_amount, 0);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_sel"}, {sel_id, sel_qty}, 0);
    check({tag, "_due"}, due_amount, 0);
    check({tag, "_credit"}, credit, 0);
    check({tag, "_chg"}, change_amount, 0);
    check({tag, "_flags"},
          {vend_valid, change_valid, error_valid,
           coin_ready, busy, error_code,
           vend_id, vend_qty}, 0);
  endtask

  initial begin
    bit ok;
    int id, qty, price, n;
    clear_in();
    product_id = '0; quantity = '0;
    coin_value = '0; discounted_price = '0;
    restock_id = '0; restock_qty = '0;
    foreach (stock_m[k]) stock_m[k] = 0;
    reset = 1'b0;
    #12;
    check_reset_outs("rst");
    @(negedge clk);
    reset = 1'b1;

    // exact pay with a late coin that must be ignored
    do_restock(1, 5);
    select(1, 5, 100, 0, 0, 0, ok);
    steps = {'h132, 'h132};
    if (ok) pay(1, 5, 100, 20);
    select(1, 1, 10, 0, 0, 0, ok);

    // overpay, change held until ack
    do_restock(4, 10);
    select(4, 1, 90, 0, 0, 0, ok);
    steps = {'h1C8};
    if (ok) pay(4, 1, 90, 0);

    do_restock(2, 3);
    select(2, 4, 10, 0, 0, 0, ok);
    select(2, 0, 10, 0, 0, 0, ok);

    // cancel together with a coin
    select(2, 1, 1000, 0, 0, 0, ok);
    steps = {'h128, 'h31E};
    if (ok) pay(2, 1, 1000, 0);

    // saturating restock, then consume all 15
    do_restock(3, 12);
    do_restock(3, 10);
    select(3, 15, 5, 0, 0, 0, ok);
    steps = {'h105};
    if (ok) pay(3, 15, 5, 0);

    // asynchronous reset in the middle of PAY
    do_restock(6, 4);
    select(6, 2, 500, 0, 0, 0, ok);
    coin_valid = 1'b1;
    coin_value = 8'd100;
    tick();
    coin_valid = 1'b0;
    check("pre_rst_credit", credit, 100);
    #2 reset = 1'b0;
    #1;
    check_reset_outs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    foreach (stock_m[k]) stock_m[k] = 0;
    select(6, 1, 10, 0, 0, 0, ok);

    repeat (80) begin
      if ($urandom_range(0, 1) == 1)
        do_restock($urandom_range(0, 7),
                   $urandom_range(0, 15));
      id  = $urandom_range(0, 7);
      qty = $urandom_range(0, 6);
      price = ($urandom_range(0, 3) == 0)
            ? 0 : $urandom_range(1, 400);
      select(id, qty, price,
             1'($urandom_range(0, 1)),
             $urandom_range(0, 7),
             $urandom_range(0, 15), ok);
      if (ok) begin
        steps = {};
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++)
          steps.push_back(
            (($urandom_range(0, 9) == 0) ? 'h200 : 0)
            | ($urandom_range(0, 1) << 8)
            | $urandom_range(0, 120));
        pay(id, qty, price, $urandom_range(0, 255));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
